// File: rtl/keypad_pkg.sv
// Shared types, default timing and the key-legend helper for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_result_e;

    localparam int DEF_NUM_ROWS        = 4;
    localparam int DEF_NUM_COLS        = 4;
    localparam int DEF_CLK_HZ          = 100_000_000;
    localparam int DEF_SCAN_HZ         = 1000;
    localparam int DEF_SETTLE_CYCLES   = 8;
    localparam int DEF_DEBOUNCE_FRAMES = 3;
    localparam int DEF_POP_CODE        = 12;

    // Printed legend of the 4x4 pad: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    function automatic logic [3:0] key_idx_to_hex(input logic [3:0] idx);
        logic [3:0] hex;
        case (idx)
            4'd0:    hex = 4'h1;
            4'd1:    hex = 4'h2;
            4'd2:    hex = 4'h3;
            4'd3:    hex = 4'hA;
            4'd4:    hex = 4'h4;
            4'd5:    hex = 4'h5;
            4'd6:    hex = 4'h6;
            4'd7:    hex = 4'hB;
            4'd8:    hex = 4'h7;
            4'd9:    hex = 4'h8;
            4'd10:   hex = 4'h9;
            4'd11:   hex = 4'hC;
            4'd12:   hex = 4'h0;
            4'd13:   hex = 4'hF;
            4'd14:   hex = 4'hE;
            default: hex = 4'hD;
        endcase
        return hex;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: commits a frame result after DEBOUNCE_FRAMES identical frames
// and turns each commit into press/release/pop pulses plus the held level.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int CW              = 4,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int POP_CODE        = DEF_POP_CODE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_frame_end,
    input  frame_result_e i_result,
    input  logic [CW-1:0] i_idx,
    output logic [CW-1:0] o_key_code,
    output logic          o_key_valid,
    output logic          o_key_release,
    output logic          o_key_held,
    output logic          o_pop_valid
);

    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);

    frame_result_e r_prev_result;
    logic [CW-1:0] r_prev_idx;
    logic [SW-1:0] r_stable;
    logic [CW-1:0] r_key_code;
    logic          r_key_valid;
    logic          r_key_release;
    logic          r_key_held;
    logic          r_pop_valid;

    logic          w_same;
    logic [SW-1:0] w_stable_next;
    logic          w_commit;

    // The key index only matters when both frames saw exactly one key.
    assign w_same = (i_result == r_prev_result) &&
                    ((i_result != SINGLE) || (i_idx == r_prev_idx));

    always_comb begin
        w_stable_next = r_stable;
        if (w_same) begin
            if (r_stable != SW'(DEBOUNCE_FRAMES)) begin
                w_stable_next = r_stable + SW'(1);
            end
        end else begin
            w_stable_next = SW'(1);
        end
        w_commit = i_frame_end && (w_stable_next == SW'(DEBOUNCE_FRAMES)) &&
                   (!w_same || (r_stable != SW'(DEBOUNCE_FRAMES)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_result <= NONE;
            r_prev_idx    <= '0;
            r_stable      <= '0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_held    <= 1'b0;
            r_pop_valid   <= 1'b0;
        end else begin
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_pop_valid   <= 1'b0;
            if (i_frame_end) begin
                r_prev_result <= i_result;
                r_prev_idx    <= i_idx;
                r_stable      <= w_stable_next;
            end
            if (w_commit) begin
                case (i_result)
                    SINGLE: begin
                        if (!r_key_held || (i_idx != r_key_code)) begin
                            r_key_code  <= i_idx;
                            r_key_held  <= 1'b1;
                            r_key_valid <= 1'b1;
                            r_pop_valid <= (i_idx == CW'(POP_CODE));
                        end
                    end
                    NONE: begin
                        if (r_key_held) begin
                            r_key_held    <= 1'b0;
                            r_key_release <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_key_code    = r_key_code;
    assign o_key_valid   = r_key_valid;
    assign o_key_release = r_key_release;
    assign o_key_held    = r_key_held;
    assign o_pop_valid   = r_pop_valid;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: steps an active-low column, samples synchronised rows once per
// column, classifies each scan frame and hands the result to the debounce stage.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS        = DEF_NUM_ROWS,
    parameter int NUM_COLS        = DEF_NUM_COLS,
    parameter int CLK_HZ          = DEF_CLK_HZ,
    parameter int SCAN_HZ         = DEF_SCAN_HZ,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int POP_CODE        = DEF_POP_CODE,
    localparam int CW = ($clog2(NUM_ROWS * NUM_COLS) > 0) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [CW-1:0]       key_code,
    output logic                key_valid,
    output logic                key_release,
    output logic                key_held,
    output logic                pop_valid,
    output logic                multi_key
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int DW    = ($clog2(DWELL) > 0) ? $clog2(DWELL) : 1;
    localparam int COLW  = ($clog2(NUM_COLS) > 0) ? $clog2(NUM_COLS) : 1;

    if (DWELL <= SETTLE_CYCLES + 2) begin : g_bad_dwell
        $error("keypad_scanner: DWELL must exceed SETTLE_CYCLES+2");
    end
    if (NUM_ROWS < 1 || NUM_COLS < 1) begin : g_bad_matrix
        $error("keypad_scanner: NUM_ROWS and NUM_COLS must be at least 1");
    end
    if (POP_CODE >= NUM_ROWS * NUM_COLS) begin : g_bad_pop
        $error("keypad_scanner: POP_CODE outside the key range");
    end
    if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_FRAMES must be at least 1");
    end

    logic [NUM_ROWS-1:0] r_sync1;
    logic [NUM_ROWS-1:0] r_sync2;
    logic [DW-1:0]       r_dwell;
    logic [COLW-1:0]     r_col;
    logic [NUM_COLS-1:0] r_col_n;
    logic [1:0]          r_cnt;
    logic [CW-1:0]       r_first_idx;
    logic                r_frame_end;
    logic                r_multi;

    logic                w_wrap;
    logic                w_sample;
    logic [COLW-1:0]     w_col_next;
    logic [1:0]          w_cnt_next;
    logic [CW-1:0]       w_first_idx_next;
    frame_result_e       w_result;

    assign w_wrap   = (r_dwell == DW'(DWELL - 1));
    assign w_sample = (r_dwell == DW'(SETTLE_CYCLES));

    always_comb begin
        w_col_next = r_col;
        if (w_wrap) begin
            w_col_next = (r_col == COLW'(NUM_COLS - 1)) ? '0 : r_col + COLW'(1);
        end
    end

    // Scan order is column-major, so the first key found is the lowest row of the lowest column.
    always_comb begin
        w_cnt_next       = r_cnt;
        w_first_idx_next = r_first_idx;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!r_sync2[r]) begin
                if (w_cnt_next == 2'd0) begin
                    w_first_idx_next = CW'(r * NUM_COLS + int'(r_col));
                end
                if (w_cnt_next != 2'd2) begin
                    w_cnt_next = w_cnt_next + 2'd1;
                end
            end
        end
    end

    always_comb begin
        case (r_cnt)
            2'd0:    w_result = NONE;
            2'd1:    w_result = SINGLE;
            default: w_result = MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_dwell     <= '0;
            r_col       <= '0;
            r_col_n     <= '1;
            r_cnt       <= '0;
            r_first_idx <= '0;
            r_frame_end <= 1'b0;
            r_multi     <= 1'b0;
        end else begin
            r_sync1     <= row_n;
            r_sync2     <= r_sync1;
            r_dwell     <= w_wrap ? '0 : r_dwell + DW'(1);
            r_col       <= w_col_next;
            r_col_n     <= ~(NUM_COLS'(1) << w_col_next);
            r_frame_end <= w_sample && (r_col == COLW'(NUM_COLS - 1));
            if (r_frame_end) begin
                r_cnt       <= '0;
                r_first_idx <= '0;
                r_multi     <= (w_result == MULTI);
            end else if (w_sample) begin
                r_cnt       <= w_cnt_next;
                r_first_idx <= w_first_idx_next;
            end
        end
    end

    keypad_debounce #(
        .CW              (CW),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .POP_CODE        (POP_CODE)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_end   (r_frame_end),
        .i_result      (w_result),
        .i_idx         (r_first_idx),
        .o_key_code    (key_code),
        .o_key_valid   (key_valid),
        .o_key_release (key_release),
        .o_key_held    (key_held),
        .o_pop_valid   (pop_valid)
    );

    assign col_n     = r_col_n;
    assign multi_key = r_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical 4x4 pad model drives the rows, and a frame-level
// reference model predicts every output on every cycle.
module tb_keypad_scanner;

    localparam int FRAME     = 40;
    localparam int RES_NONE  = -1;
    localparam int RES_MULTI = -2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_release;
    logic        key_held;
    logic        pop_valid;
    logic        multi_key;

    logic [15:0] keys_down;
    int          cyc;
    int          n_checks;
    int          n_errors;

    // Frame-level reference state.
    int          hist[$];
    logic [3:0]  exp_code;
    logic        exp_held;
    logic        exp_multi;
    logic        exp_kv;
    logic        exp_kr;
    logic        exp_pop;

    keypad_scanner #(
        .NUM_ROWS        (4),
        .NUM_COLS        (4),
        .CLK_HZ          (1000),
        .SCAN_HZ         (100),
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_FRAMES (3),
        .POP_CODE        (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_held    (key_held),
        .pop_valid   (pop_valid),
        .multi_key   (multi_key)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // A pressed switch shorts its row to its column: a row reads low when any pressed key
    // on it sits in a column that is currently driven low.
    function automatic logic [3:0] pad_rows(input logic [3:0] cn, input logic [15:0] k);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (k[r*4+c] && !cn[c]) rows[r] = 1'b0;
        return rows;
    endfunction

    assign row_n = pad_rows(col_n, keys_down);

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int frame_result(input logic [15:0] k);
        int n;
        int first;
        n = 0;
        first = -1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (k[r*4+c]) begin
                    if (first < 0) first = r*4 + c;
                    n++;
                end
        if (n == 0) return RES_NONE;
        if (n >= 2) return RES_MULTI;
        return first;
    endfunction

    function automatic logic [3:0] exp_cols(input int t);
        logic [3:0] one;
        one = 4'b0001;
        if (t == 0) return 4'hF;
        return ~(one << ((t / 10) % 4));
    endfunction

    task automatic model_frame(input logic [15:0] k);
        int res;
        int run;
        res = frame_result(k);
        hist.push_back(res);
        if (hist.size() > 8) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != res) break;
            run++;
        end
        exp_multi = (res == RES_MULTI);
        if (run == 3) begin
            if (res >= 0) begin
                if (!exp_held || exp_code != 4'(res)) begin
                    exp_code = 4'(res);
                    exp_held = 1'b1;
                    exp_kv   = 1'b1;
                    exp_pop  = (res == 12);
                end
            end else if (res == RES_NONE && exp_held) begin
                exp_held = 1'b0;
                exp_kr   = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_code  = 4'h0;
        exp_held  = 1'b0;
        exp_multi = 1'b0;
        exp_kv    = 1'b0;
        exp_kr    = 1'b0;
        exp_pop   = 1'b0;
    endtask

    // Frame k samples during cycles 40k+4..40k+34; its committed effects show in cycle 40k+36.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_kv  = 1'b0;
                exp_kr  = 1'b0;
                exp_pop = 1'b0;
                if (cyc >= 36 && cyc % FRAME == 36) model_frame(keys_down);
                check_eq("col_n",       col_n,       exp_cols(cyc));
                check_eq("key_code",    key_code,    exp_code);
                check_eq("key_held",    key_held,    exp_held);
                check_eq("key_valid",   key_valid,   exp_kv);
                check_eq("key_release", key_release, exp_kr);
                check_eq("pop_valid",   pop_valid,   exp_pop);
                check_eq("multi_key",   multi_key,   exp_multi);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Key changes land between frames, so each frame sees one steady key set.
    task automatic next_frame(input logic [15:0] k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc % FRAME != 38 && n < 45);
        check_eq("frame_sync", cyc % FRAME, 38);
        keys_down = k;
    endtask

    task automatic run_frames(input logic [15:0] k, input int frames);
        for (int i = 0; i < frames; i++) next_frame(k);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_col_n"},   col_n,       4'hF);
        check_eq({tag, "_code"},    key_code,    4'h0);
        check_eq({tag, "_valid"},   key_valid,   1'b0);
        check_eq({tag, "_release"}, key_release, 1'b0);
        check_eq({tag, "_held"},    key_held,    1'b0);
        check_eq({tag, "_pop"},     pop_valid,   1'b0);
        check_eq({tag, "_multi"},   multi_key,   1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] k;
        int sel;
        int n;
        n_checks  = 0;
        n_errors  = 0;
        keys_down = 16'h0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_frames(16'h0000, 3);                 // idle scan
        run_frames(16'h0040, 5);                 // key 6 (row 1, col 2)
        run_frames(16'h0000, 4);                 // release key 6
        run_frames(16'h1000, 4);                 // key 12: pop key
        run_frames(16'h0000, 4);
        for (int i = 0; i < 3; i++) begin        // bouncing key 9
            run_frames(16'h0200, 1);
            run_frames(16'h0000, 1);
        end
        run_frames(16'h0200, 4);
        run_frames(16'h0042, 4);                 // keys 1 and 6 together
        run_frames(16'h0002, 4);                 // key 6 released, key 1 remains

        // Reset in the middle of a frame, then require a fresh commit.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc % FRAME != 20 && n < 45);
        rst_n = 1'b0;
        keys_down = 16'h0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(16'h0008, 4);
        run_frames(16'h0000, 4);

        // Random key sets, each held for a random number of frames.
        for (int seg = 0; seg < 30; seg++) begin
            k = 16'h0;
            sel = $urandom_range(0, 9);
            if (sel >= 4) k[$urandom_range(0, 15)] = 1'b1;
            if (sel >= 8) k[$urandom_range(0, 15)] = 1'b1;
            run_frames(k, $urandom_range(1, 4));
        end
        run_frames(16'h0000, 4);
        repeat (FRAME + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
